alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational 8-bit ALU between NREQ independent requesters. Each requester presents operands A, B and a 4-bit select over a valid/ready handshake. The block grants one requester at a time, drives the ALU from registered operands and returns the registered result and carry to the granted requester with its ID. It sits between the requester clients and the `alu` instance, which connects directly to the `alu_*` ports.

## Interface
- NREQ, 2: number of requesters (2..8)
- IDW, 3: width of response ID; must satisfy 2^IDW >= NREQ
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept strobe, one-hot or zero
- req_a  input  NREQ*8  operand A, requester i at bits [8i+7:8i]
- req_b  input  NREQ*8  operand B, same packing
- req_sel  input  NREQ*4  ALU select, requester i at bits [4i+3:4i]
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_sel  output  4  to ALU ALU_Sel
- alu_out  input  8  from ALU ALU_Out
- alu_carry  input  1  from ALU CarryOut
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  IDW  index of requester owning the result
- resp_data  output  8  captured ALU_Out
- resp_carry  output  1  captured CarryOut

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req_valid is high, pick winner w (see Configuration) and assert req_ready[w] combinationally in that same cycle. On that clock edge, latch req_a/b/sel slice w into alu_a/alu_b/alu_sel, latch w into the ID register and go to ISSUE. If no request is valid, stay in IDLE with req_ready = 0.
- ISSUE: the ALU is driven from the registers. On the edge, capture alu_out/alu_carry into resp_data/resp_carry and go to RESP.
- RESP: resp_valid = 1, and resp_id/data/carry are stable. If resp_ready is high, go to IDLE on that edge; otherwise hold all response outputs unchanged.
- req_ready is 0 in ISSUE and RESP. Requesters must hold req_valid and their operands until they see ready.
- Round-robin pointer: after a grant to w, the next search starts at w+1 mod NREQ. A requester that drops valid before being granted simply loses its turn. Nothing is queued.
- alu_sel is passed through unchanged. The arbiter does not interpret the code, so undefined codes yield whatever the ALU outputs.
- alu_a/alu_b/alu_sel hold their last-issued values in RESP and IDLE.

## Timing
- Reset values: state IDLE, req_ready 0, alu_a/alu_b/alu_sel 0, resp_valid 0, resp_id/data/carry 0, RR pointer 0.
- Accept edge is T (valid & ready). The ALU sees new operands during T+1. resp_valid rises in cycle T+2.
- Minimum spacing between accepts is 3 cycles (IDLE→ISSUE→RESP→IDLE). When resp_ready is tied high, a new accept can occur at T+3.
- When multiple requests are valid simultaneously, exactly one req_ready bit is set.
- resp_ready has no effect outside RESP.
- A reset asserted in any state returns the block to IDLE on the next edge. Any in-flight operation and any pending response are discarded without a response, and the RR pointer returns to 0.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins, and the RR pointer logic is removed.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.

## Test plan
- Single op: requester 0 sends A=0x0A, B=0x02, sel=0 with resp_ready=1 → req_ready[0] at T, alu_a=0x0A at T+1, resp_valid at T+2 with resp_id=0 and resp_data equal to the ALU add result 0x0C.
- Sweep: requester 1 issues sel 0..11 with A=0xF6, B=0x0A → 12 responses in order, resp_id=1, and data/carry match the ALU model. For sel=0 the response is data=0x00 with carry=1.
- Contention (round-robin build): both requesters hold valid continuously for 6 grants → grant order is 0,1,0,1,0,1. With ALU_ARB_FIXED_PRIO_EN the order is 0,0,0,0,0,0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid stays 1, data/id are stable, req_ready is 0 throughout, and the state advances to IDLE only on the edge where resp_ready=1.
- Reset mid-op: assert rst during ISSUE → the next cycle shows all outputs at reset values and no resp_valid. The next grant goes to requester 0 when both are valid.
- Idle: no req_valid for 20 cycles → req_ready=0, resp_valid=0, and alu_* hold their prior values.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and response bundle between the clients and alu_arbiter.
// Packing: requester i owns req_a/req_b[8i+7:8i] and req_sel[4i+3:4i].
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*4-1:0] req_sel;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_data;
  logic              resp_carry;

  modport master (
    output req_valid, req_a, req_b, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between NREQ requesters (IDLE -> ISSUE -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority; default build is round-robin.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_sel,
  input  logic [7:0]   alu_out,
  input  logic         alu_carry
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_s;
  logic [PW-1:0]   base_s;
  logic [NREQ-1:0] rot_s;
  logic [PW-1:0]   off_s;
  logic [PW:0]     sum_s;
  logic [PW-1:0]   win_s;
  logic            found_s;
  logic            grant_s;
  logic [NREQ-1:0] req_ready_s;
  logic [7:0]      win_a_s;
  logic [7:0]      win_b_s;
  logic [3:0]      win_sel_s;
  logic [7:0]      alu_a_r;
  logic [7:0]      alu_b_r;
  logic [3:0]      alu_sel_r;
  logic [IDW-1:0]  id_r;
  logic [7:0]      data_r;
  logic            carry_r;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign base_s = '0;
`else
  logic [PW-1:0] rr_ptr_r;

  assign base_s = rr_ptr_r;

  // Round-robin pointer: search restarts one past the last winner
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= (win_s == PW'(NREQ - 1)) ? '0 : win_s + PW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Winner search: rotate valids so the start index sits at bit 0, pick the lowest set bit
  always_comb begin
    rot_s   = NREQ'({bus.req_valid, bus.req_valid} >> base_s);
    off_s   = '0;
    found_s = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      off_s   = rot_s[i] ? PW'(i) : off_s;
      found_s = found_s | rot_s[i];
    end
    sum_s = {1'b0, base_s} + {1'b0, off_s};
    win_s = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);
  end

  // Operand mux for the current winner
  always_comb begin
    win_a_s   = 8'h00;
    win_b_s   = 8'h00;
    win_sel_s = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      win_a_s   = (win_s == PW'(i)) ? bus.req_a[8*i +: 8]   : win_a_s;
      win_b_s   = (win_s == PW'(i)) ? bus.req_b[8*i +: 8]   : win_b_s;
      win_sel_s = (win_s == PW'(i)) ? bus.req_sel[4*i +: 4] : win_sel_s;
    end
  end

  // Next-state and accept strobe; ready is suppressed while reset is held
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        grant_s = found_s & ~rst;
        state_s = grant_s ? ISSUE : IDLE;
      end
      ISSUE: state_s = RESP;
      RESP:  state_s = bus.resp_ready ? IDLE : RESP;
      default: state_s = IDLE;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req_ready_s[i] = grant_s & (win_s == PW'(i));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand/ID capture on accept, result capture while the ALU is driven
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_r   <= 8'h00;
      alu_b_r   <= 8'h00;
      alu_sel_r <= 4'h0;
      id_r      <= '0;
      data_r    <= 8'h00;
      carry_r   <= 1'b0;
    end else begin
      if (grant_s) begin
        alu_a_r   <= win_a_s;
        alu_b_r   <= win_b_s;
        alu_sel_r <= win_sel_s;
        id_r      <= IDW'(win_s);
      end
      if (state_r == ISSUE) begin
        data_r  <= alu_out;
        carry_r <= alu_carry;
      end
    end
  end

  assign alu_a          = alu_a_r;
  assign alu_b          = alu_b_r;
  assign alu_sel        = alu_sel_r;
  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_id    = id_r;
  assign bus.resp_data  = data_r;
  assign bus.resp_carry = carry_r;
endmodule
